// File: rtl/pipeline_stall_controller.sv
// Freeze/flush/bubble sequencer for the 5-stage pipeline: memory-wait FSM, wait-timeout counter, fatal HALT.
// Optional performance counters are compiled in when STALL_PERF_CNT_EN is defined.
module pipeline_stall_controller #(
    parameter int WAIT_CNT_W  = 8,
    parameter int MEM_TIMEOUT = 200
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_hazard_detected,
    input  logic        i_branch_taken,
    input  logic        i_mem_req,
    input  logic        i_mem_ready,
    output logic        o_pc_freeze,
    output logic        o_if_id_freeze,
    output logic        o_if_id_flush,
    output logic        o_id_exe_bubble,
    output logic        o_exe_mem_freeze,
    output logic        o_mem_wb_bubble,
    output logic        o_mem_timeout,
`ifdef STALL_PERF_CNT_EN
    output logic [31:0] o_perf_stall_cycles,
    output logic [31:0] o_perf_flushes,
    output logic [31:0] o_perf_mem_wait,
`endif
    output logic [1:0]  o_ctrl_state
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_HALT     = 2'd2
    } state_t;

    localparam logic [WAIT_CNT_W-1:0] TIMEOUT_VAL = WAIT_CNT_W'(MEM_TIMEOUT);
    localparam logic [WAIT_CNT_W-1:0] CNT_ONE     = WAIT_CNT_W'(1);

    state_t                r_state;
    logic [WAIT_CNT_W-1:0] r_wait_cnt;
    logic                  w_mem_stall;

    // A dropped mem_req during a wait is treated as completion, so RUN and MEM_WAIT share this test.
    assign w_mem_stall  = i_mem_req & ~i_mem_ready;
    assign o_ctrl_state = r_state;

    always_comb begin
        o_pc_freeze      = 1'b0;
        o_if_id_freeze   = 1'b0;
        o_if_id_flush    = 1'b0;
        o_id_exe_bubble  = 1'b0;
        o_exe_mem_freeze = 1'b0;
        o_mem_wb_bubble  = 1'b0;
        o_mem_timeout    = 1'b0;
        if (i_rst_n) begin
            case (r_state)
                ST_RUN, ST_MEM_WAIT: begin
                    if (w_mem_stall) begin
                        o_pc_freeze      = 1'b1;
                        o_if_id_freeze   = 1'b1;
                        o_exe_mem_freeze = 1'b1;
                        o_mem_wb_bubble  = 1'b1;
                    end else if (i_branch_taken) begin
                        o_if_id_flush    = 1'b1;
                        o_id_exe_bubble  = 1'b1;
                    end else if (i_hazard_detected) begin
                        o_pc_freeze      = 1'b1;
                        o_if_id_freeze   = 1'b1;
                        o_id_exe_bubble  = 1'b1;
                    end
                end
                ST_HALT: begin
                    o_pc_freeze      = 1'b1;
                    o_if_id_freeze   = 1'b1;
                    o_exe_mem_freeze = 1'b1;
                    o_mem_wb_bubble  = 1'b1;
                    o_mem_timeout    = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    // The counter holds the index of the current MEM_WAIT cycle and saturates at the timeout.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= ST_RUN;
            r_wait_cnt <= '0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_mem_stall) begin
                        r_state    <= ST_MEM_WAIT;
                        r_wait_cnt <= CNT_ONE;
                    end
                end
                ST_MEM_WAIT: begin
                    if (w_mem_stall) begin
                        if (r_wait_cnt >= TIMEOUT_VAL) begin
                            r_state    <= ST_HALT;
                            r_wait_cnt <= TIMEOUT_VAL;
                        end else begin
                            r_wait_cnt <= r_wait_cnt + CNT_ONE;
                        end
                    end else begin
                        r_state    <= ST_RUN;
                        r_wait_cnt <= '0;
                    end
                end
                ST_HALT: begin
                    r_state <= ST_HALT;
                end
                default: begin
                    r_state    <= ST_RUN;
                    r_wait_cnt <= '0;
                end
            endcase
        end
    end

`ifdef STALL_PERF_CNT_EN
    logic [31:0] r_perf_stall_cycles;
    logic [31:0] r_perf_flushes;
    logic [31:0] r_perf_mem_wait;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_perf_stall_cycles <= '0;
            r_perf_flushes      <= '0;
            r_perf_mem_wait     <= '0;
        end else begin
            if (o_pc_freeze && (r_perf_stall_cycles != '1))
                r_perf_stall_cycles <= r_perf_stall_cycles + 32'd1;
            if (o_if_id_flush && (r_perf_flushes != '1))
                r_perf_flushes <= r_perf_flushes + 32'd1;
            if ((r_state == ST_MEM_WAIT) && (r_perf_mem_wait != '1))
                r_perf_mem_wait <= r_perf_mem_wait + 32'd1;
        end
    end

    assign o_perf_stall_cycles = r_perf_stall_cycles;
    assign o_perf_flushes      = r_perf_flushes;
    assign o_perf_mem_wait     = r_perf_mem_wait;
`endif

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Scoreboard bench for pipeline_stall_controller: driver pushes model expectations, negedge monitor compares.
// Perf-counter checks are included when STALL_PERF_CNT_EN is defined.
module tb_pipeline_stall_controller;

    localparam int TIMEOUT = 4;

    logic clk;
    logic rstN;
    logic hazard, branch, memReq, memReady;
    logic pcFreeze, ifIdFreeze, ifIdFlush, idExeBubble, exeMemFreeze, memWbBubble, memTimeout;
    logic [1:0] ctrlState;
`ifdef STALL_PERF_CNT_EN
    logic [31:0] perfStall, perfFlush, perfMemWait;
`endif

    pipeline_stall_controller #(.WAIT_CNT_W(8), .MEM_TIMEOUT(TIMEOUT)) dut (
        .i_clk             (clk),
        .i_rst_n           (rstN),
        .i_hazard_detected (hazard),
        .i_branch_taken    (branch),
        .i_mem_req         (memReq),
        .i_mem_ready       (memReady),
        .o_pc_freeze       (pcFreeze),
        .o_if_id_freeze    (ifIdFreeze),
        .o_if_id_flush     (ifIdFlush),
        .o_id_exe_bubble   (idExeBubble),
        .o_exe_mem_freeze  (exeMemFreeze),
        .o_mem_wb_bubble   (memWbBubble),
        .o_mem_timeout     (memTimeout),
`ifdef STALL_PERF_CNT_EN
        .o_perf_stall_cycles (perfStall),
        .o_perf_flushes      (perfFlush),
        .o_perf_mem_wait     (perfMemWait),
`endif
        .o_ctrl_state      (ctrlState)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ctl bit order: pcFreeze, ifIdFreeze, ifIdFlush, idExeBubble, exeMemFreeze, memWbBubble, memTimeout
    typedef struct {
        logic [6:0]  ctl;
        logic [1:0]  st;
        logic [31:0] perfStall;
        logic [31:0] perfFlush;
        logic [31:0] perfMemWait;
    } exp_t;

    exp_t expQ[$];
    int   checks = 0;
    int   errors = 0;

    bit      mdlHalted;
    bit      mdlWaiting;
    int      mdlWaitCycles;
    longint  mdlPerfStall, mdlPerfFlush, mdlPerfMemWait;

    function automatic logic [31:0] sat32(longint v);
        return (v > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : v[31:0];
    endfunction

    function automatic exp_t modelOutputs(bit h, bit b, bit req, bit rdy, bit inReset);
        exp_t e;
        e.ctl = 7'b0;
        e.st  = 2'd0;
        if (!inReset) begin
            if (mdlHalted) begin
                e.ctl = 7'b1100111;
                e.st  = 2'd2;
            end else begin
                e.st = mdlWaiting ? 2'd1 : 2'd0;
                if (req && !rdy)  e.ctl = 7'b1100110;
                else if (b)       e.ctl = 7'b0011000;
                else if (h)       e.ctl = 7'b1101000;
            end
        end
        e.perfStall   = sat32(mdlPerfStall);
        e.perfFlush   = sat32(mdlPerfFlush);
        e.perfMemWait = sat32(mdlPerfMemWait);
        return e;
    endfunction

    task automatic modelAdvance(bit req, bit rdy, exp_t e);
        mdlPerfStall   += e.ctl[6];
        mdlPerfFlush   += e.ctl[4];
        mdlPerfMemWait += (e.st == 2'd1) ? 1 : 0;
        if (mdlHalted) return;
        if (req && !rdy) begin
            if (!mdlWaiting) begin
                mdlWaiting    = 1'b1;
                mdlWaitCycles = 0;
            end else begin
                mdlWaitCycles++;
                if (mdlWaitCycles >= TIMEOUT) begin
                    mdlHalted  = 1'b1;
                    mdlWaiting = 1'b0;
                end
            end
        end else begin
            mdlWaiting    = 1'b0;
            mdlWaitCycles = 0;
        end
    endtask

    task automatic modelReset();
        mdlHalted      = 1'b0;
        mdlWaiting     = 1'b0;
        mdlWaitCycles  = 0;
        mdlPerfStall   = 0;
        mdlPerfFlush   = 0;
        mdlPerfMemWait = 0;
    endtask

    task automatic applyStimulus(bit h, bit b, bit req, bit rdy);
        exp_t e;
        hazard   = h;
        branch   = b;
        memReq   = req;
        memReady = rdy;
        e = modelOutputs(h, b, req, rdy, 1'b0);
        expQ.push_back(e);
        @(posedge clk);
        #1;
        modelAdvance(req, rdy, e);
    endtask

    // Reset is asserted mid-cycle, so the following negedge check proves it acts without a clock edge.
    task automatic applyReset(int cycles);
        exp_t e;
        rstN = 1'b0;
        modelReset();
        for (int k = 0; k < cycles; k++) begin
            hazard   = 1'($urandom_range(0, 1));
            branch   = 1'($urandom_range(0, 1));
            memReq   = 1'($urandom_range(0, 1));
            memReady = 1'($urandom_range(0, 1));
            e = modelOutputs(hazard, branch, memReq, memReady, 1'b1);
            expQ.push_back(e);
            @(posedge clk);
            #1;
        end
        rstN = 1'b1;
    endtask

    task automatic checkOutput(exp_t e);
        logic [6:0] act;
        act = {pcFreeze, ifIdFreeze, ifIdFlush, idExeBubble, exeMemFreeze, memWbBubble, memTimeout};
        checks++;
        if (act !== e.ctl || ctrlState !== e.st) begin
            errors++;
            $display("[TB] FAIL ctrl t=%0t: got ctl=%b state=%0d, expected ctl=%b state=%0d",
                     $time, act, ctrlState, e.ctl, e.st);
        end
`ifdef STALL_PERF_CNT_EN
        checks++;
        if (perfStall !== e.perfStall || perfFlush !== e.perfFlush || perfMemWait !== e.perfMemWait) begin
            errors++;
            $display("[TB] FAIL perf t=%0t: got %0d/%0d/%0d, expected %0d/%0d/%0d", $time,
                     perfStall, perfFlush, perfMemWait, e.perfStall, e.perfFlush, e.perfMemWait);
        end
`endif
    endtask

    always @(negedge clk) begin
        if (expQ.size() > 0) checkOutput(expQ.pop_front());
    end

    initial begin
        rstN = 1'b0; hazard = 1'b0; branch = 1'b0; memReq = 1'b0; memReady = 1'b0;
        modelReset();
        @(posedge clk);
        #1;
        applyReset(3);

        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0);
        applyStimulus(1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0);
        applyStimulus(1, 1, 0, 0);
        applyStimulus(0, 0, 1, 1);
        applyStimulus(1, 0, 1, 1);

        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 1, 0);
        applyStimulus(0, 1, 1, 1);
        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 1, 0);
        applyStimulus(1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0);

        for (int i = 0; i < TIMEOUT + 2; i++) applyStimulus(0, 0, 1, 0);
        for (int i = 0; i < 6; i++) applyStimulus(1, 1, 1, 1'(i % 2));
        applyReset(1);
        applyStimulus(0, 0, 0, 0);

        applyReset(1);
        for (int i = 0; i < 5; i++) applyStimulus(1, 0, 0, 0);
        applyStimulus(0, 1, 0, 0);
        applyStimulus(0, 1, 0, 0);
        applyStimulus(0, 0, 0, 0);

        for (int it = 0; it < 1500; it++) begin
            int mode;
            if (mdlHalted && $urandom_range(0, 3) == 0) applyReset($urandom_range(1, 2));
            mode = $urandom_range(0, 19);
            if (mode < 13) begin
                applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
                              1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0));
            end else if (mode < 19) begin
                int len;
                len = $urandom_range(1, TIMEOUT + 3);
                for (int k = 0; k < len; k++)
                    applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1, 0);
                applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                              1'($urandom_range(0, 1)), 1);
            end else begin
                applyReset(1);
            end
        end

        applyStimulus(0, 0, 0, 0);
        @(negedge clk);
        #1;
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: got %0d pending expectations, expected 0", expQ.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
